// File: rtl/fir_ram_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// fir_ram_sweep_ctrl
//
// Control generator for the 4-bank SpSram FIR core. Each sample tick starts
// one coefficient read sweep over taps 0..NUM_TAPS-1 on all banks at once.
// The sweep drives the MAC pipeline strobes and finishes with an output-valid
// pulse. In coefficient update mode, host writes are routed to a single bank
// instead. Both paths share the same bank ports.
//
// Ports
//   iClk12M          12 MHz clock, single clock domain
//   iRst             synchronous active-high reset
//   iEnSample600k    1-cycle sample tick
//   iCoeffUpdateFlag level, 1 = coefficient update mode
//   iWrValid         host write request
//   iWrAddr          {bank, tap} write address
//   iWrData          host write data
//   oWrReady         write accepted when iWrValid & oWrReady (state == UPDATE)
//   oCsnRam          per-bank chip select, active-low
//   oWrnRam          0 = write, 1 = read
//   oAddrRam         tap address to all banks
//   oWtDtRam         write data to all banks
//   oEnDelay         pulse: shift input delay line
//   oAccClr          pulse: clear accumulator
//   oEnMul           multiplier enable
//   oEnAddAcc        accumulate enable
//   oOutValid        pulse: filter output valid
//   oTickMiss        pulse: sample tick dropped
//   oWrErr           pulse: write to tap >= NUM_TAPS dropped
//
// Every output except oWrReady is registered.
// -----------------------------------------------------------------------------
module fir_ram_sweep_ctrl #(
    parameter int unsigned NUM_TAPS = 10,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_BANK = 4,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                iClk12M,
    input  logic                iRst,
    input  logic                iEnSample600k,
    input  logic                iCoeffUpdateFlag,
    input  logic                iWrValid,
    input  logic [ADDR_W+1:0]   iWrAddr,
    input  logic [DATA_W-1:0]   iWrData,
    output logic                oWrReady,
    output logic [NUM_BANK-1:0] oCsnRam,
    output logic                oWrnRam,
    output logic [ADDR_W-1:0]   oAddrRam,
    output logic [DATA_W-1:0]   oWtDtRam,
    output logic                oEnDelay,
    output logic                oAccClr,
    output logic                oEnMul,
    output logic                oEnAddAcc,
    output logic                oOutValid,
    output logic                oTickMiss,
    output logic                oWrErr
);

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        READ,
        DRAIN,
        OUT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

    state_t              state;
    state_t              stateNext;
    logic [ADDR_W-1:0]   tapCnt;
    logic [ADDR_W-1:0]   tapCntNext;

    logic [NUM_BANK-1:0] csnNext;
    logic                wrnNext;
    logic [ADDR_W-1:0]   addrNext;
    logic [DATA_W-1:0]   dataNext;
    logic                enDelayNext;
    logic                accClrNext;
    logic                enMulNext;
    logic                enAddAccNext;
    logic                outValidNext;
    logic                tickMissNext;
    logic                wrErrNext;

    logic                wrAccept;
    logic [1:0]          wrBank;
    logic [ADDR_W-1:0]   wrTap;
    logic                wrTapOk;
    logic                readIssued;

    assign oWrReady   = (state == UPDATE);
    assign wrAccept   = iWrValid && oWrReady;
    assign wrBank     = iWrAddr[ADDR_W+1:ADDR_W];
    assign wrTap      = iWrAddr[ADDR_W-1:0];
    assign wrTapOk    = (32'(wrTap) < NUM_TAPS);
    // A read is on the bank ports this cycle: every bank selected, read mode.
    // A host write only ever selects one bank, so it never matches.
    assign readIssued = (oCsnRam == '0) && oWrnRam;

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state     <= IDLE;
            tapCnt    <= '0;
            oCsnRam   <= '1;
            oWrnRam   <= 1'b1;
            oAddrRam  <= '0;
            oWtDtRam  <= '0;
            oEnDelay  <= 1'b0;
            oAccClr   <= 1'b0;
            oEnMul    <= 1'b0;
            oEnAddAcc <= 1'b0;
            oOutValid <= 1'b0;
            oTickMiss <= 1'b0;
            oWrErr    <= 1'b0;
        end else begin
            state     <= stateNext;
            tapCnt    <= tapCntNext;
            oCsnRam   <= csnNext;
            oWrnRam   <= wrnNext;
            oAddrRam  <= addrNext;
            oWtDtRam  <= dataNext;
            oEnDelay  <= enDelayNext;
            oAccClr   <= accClrNext;
            oEnMul    <= enMulNext;
            oEnAddAcc <= enAddAccNext;
            oOutValid <= outValidNext;
            oTickMiss <= tickMissNext;
            oWrErr    <= wrErrNext;
        end
    end

    always_comb begin
        stateNext    = state;
        tapCntNext   = tapCnt;
        csnNext      = '1;
        wrnNext      = 1'b1;
        addrNext     = oAddrRam;
        dataNext     = oWtDtRam;
        enDelayNext  = 1'b0;
        // MAC strobes trail the RAM read by the read latency and then
        // by the multiply latency.
        accClrNext   = oEnDelay;
        enMulNext    = readIssued;
        enAddAccNext = oEnMul;
        outValidNext = 1'b0;
        tickMissNext = 1'b0;
        wrErrNext    = 1'b0;

        unique case (state)
            IDLE: begin
                if (iCoeffUpdateFlag) begin
                    stateNext    = UPDATE;
                    tickMissNext = iEnSample600k;
                end else if (iEnSample600k) begin
                    stateNext   = READ;
                    tapCntNext  = '0;
                    csnNext     = '0;
                    addrNext    = '0;
                    enDelayNext = 1'b1;
                end
            end

            UPDATE: begin
                tickMissNext = iEnSample600k;
                if (!iCoeffUpdateFlag) begin
                    stateNext = IDLE;
                end
                // oWrReady is still high on the last UPDATE cycle, so a
                // write accepted there is issued as usual.
                if (wrAccept) begin
                    if (wrTapOk) begin
                        for (int unsigned b = 0; b < NUM_BANK; b++) begin
                            if (32'(wrBank) == b) begin
                                csnNext[b] = 1'b0;
                            end
                        end
                        wrnNext  = 1'b0;
                        addrNext = wrTap;
                        dataNext = iWrData;
                    end else begin
                        wrErrNext = 1'b1;
                    end
                end
            end

            READ: begin
                tickMissNext = iEnSample600k;
                // tapCnt holds the address on the ports now. It stops at the
                // last tap and does not wrap.
                if (tapCnt == LAST_TAP) begin
                    stateNext = DRAIN;
                end else begin
                    tapCntNext = tapCnt + ADDR_W'(1);
                    csnNext    = '0;
                    addrNext   = tapCnt + ADDR_W'(1);
                end
            end

            DRAIN: begin
                tickMissNext = iEnSample600k;
                // Multiplier idle while the last accumulate is in progress.
                // At the next edge the final product is in the accumulator.
                if (!oEnMul && oEnAddAcc) begin
                    stateNext    = OUT;
                    outValidNext = 1'b1;
                end
            end

            OUT: begin
                tickMissNext = iEnSample600k;
                stateNext    = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_ram_sweep_ctrl.sv
module tb_fir_ram_sweep_ctrl;

    logic        iClk12M;
    logic        iRst;
    logic        iEnSample600k;
    logic        iCoeffUpdateFlag;
    logic        iWrValid;
    logic [5:0]  iWrAddr;
    logic [15:0] iWrData;
    logic        oWrReady;
    logic [3:0]  oCsnRam;
    logic        oWrnRam;
    logic [3:0]  oAddrRam;
    logic [15:0] oWtDtRam;
    logic        oEnDelay;
    logic        oAccClr;
    logic        oEnMul;
    logic        oEnAddAcc;
    logic        oOutValid;
    logic        oTickMiss;
    logic        oWrErr;

    int nCompared;
    int nMismatched;

    fir_ram_sweep_ctrl #(
        .NUM_TAPS (10),
        .ADDR_W   (4),
        .NUM_BANK (4),
        .DATA_W   (16)
    ) dut (
        .iClk12M          (iClk12M),
        .iRst             (iRst),
        .iEnSample600k    (iEnSample600k),
        .iCoeffUpdateFlag (iCoeffUpdateFlag),
        .iWrValid         (iWrValid),
        .iWrAddr          (iWrAddr),
        .iWrData          (iWrData),
        .oWrReady         (oWrReady),
        .oCsnRam          (oCsnRam),
        .oWrnRam          (oWrnRam),
        .oAddrRam         (oAddrRam),
        .oWtDtRam         (oWtDtRam),
        .oEnDelay         (oEnDelay),
        .oAccClr          (oAccClr),
        .oEnMul           (oEnMul),
        .oEnAddAcc        (oEnAddAcc),
        .oOutValid        (oOutValid),
        .oTickMiss        (oTickMiss),
        .oWrErr           (oWrErr)
    );

    initial iClk12M = 1'b0;
    always #5 iClk12M = ~iClk12M;

    // Outputs are sampled 1 time unit after the rising edge; inputs are
    // changed at the same point and take effect at the next edge.
    task automatic stepClk();
        @(posedge iClk12M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tick at edge T, then observe T+1..T+14.
    // missAt: after observing T+missAt, send another tick (0 = none).
    // flagAt: after observing T+flagAt, raise the update flag and a write (0 = none).
    task automatic runSweep(input string tag, input int missAt, input int flagAt);
        iEnSample600k = 1'b1;
        stepClk();
        iEnSample600k = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            chk($sformatf("%s csn k%0d", tag, k), 32'(oCsnRam), (k <= 10) ? 32'h0 : 32'hF);
            if (k <= 10) chk($sformatf("%s addr k%0d", tag, k), 32'(oAddrRam), 32'(k - 1));
            chk($sformatf("%s wrn k%0d", tag, k), 32'(oWrnRam), 32'd1);
            chk($sformatf("%s enDelay k%0d", tag, k), 32'(oEnDelay), 32'(k == 1));
            chk($sformatf("%s accClr k%0d", tag, k), 32'(oAccClr), 32'(k == 2));
            chk($sformatf("%s enMul k%0d", tag, k), 32'(oEnMul), 32'(k >= 2 && k <= 11));
            chk($sformatf("%s enAddAcc k%0d", tag, k), 32'(oEnAddAcc), 32'(k >= 3 && k <= 12));
            chk($sformatf("%s outValid k%0d", tag, k), 32'(oOutValid), 32'(k == 13));
            chk($sformatf("%s tickMiss k%0d", tag, k), 32'(oTickMiss), 32'(missAt != 0 && k == missAt + 1));
            chk($sformatf("%s wrReady k%0d", tag, k), 32'(oWrReady), 32'd0);
            chk($sformatf("%s wrErr k%0d", tag, k), 32'(oWrErr), 32'd0);
            if (k == missAt) iEnSample600k = 1'b1;
            if (k == flagAt) begin
                iCoeffUpdateFlag = 1'b1;
                iWrValid         = 1'b1;
                iWrAddr          = {2'd1, 4'd3};
                iWrData          = 16'hBEEF;
            end
            if (k < 14) begin
                stepClk();
                iEnSample600k = 1'b0;
            end
        end
    endtask

    task automatic doWrite(input logic [5:0] addr, input logic [15:0] data);
        iWrValid = 1'b1;
        iWrAddr  = addr;
        iWrData  = data;
        stepClk();
        iWrValid = 1'b0;
    endtask

    initial begin
        nCompared        = 0;
        nMismatched      = 0;
        iRst             = 1'b1;
        iEnSample600k    = 1'b0;
        iCoeffUpdateFlag = 1'b0;
        iWrValid         = 1'b0;
        iWrAddr          = '0;
        iWrData          = '0;

        // Reset state
        repeat (3) stepClk();
        chk("rst csn", 32'(oCsnRam), 32'hF);
        chk("rst wrn", 32'(oWrnRam), 32'd1);
        chk("rst addr", 32'(oAddrRam), 32'd0);
        chk("rst data", 32'(oWtDtRam), 32'd0);
        chk("rst pulses", 32'({oEnDelay, oAccClr, oEnMul, oEnAddAcc, oOutValid, oTickMiss, oWrErr}), 32'd0);
        chk("rst wrReady", 32'(oWrReady), 32'd0);
        iRst = 1'b0;
        repeat (2) stepClk();

        // Plain sweep
        runSweep("sweep", 0, 0);
        stepClk();
        chk("sweep post outValid", 32'(oOutValid), 32'd0);

        // Tick and flag together in IDLE: update wins, tick dropped
        iCoeffUpdateFlag = 1'b1;
        iEnSample600k    = 1'b1;
        stepClk();
        iEnSample600k = 1'b0;
        chk("tickflag tickMiss", 32'(oTickMiss), 32'd1);
        chk("tickflag wrReady", 32'(oWrReady), 32'd1);
        chk("tickflag enDelay", 32'(oEnDelay), 32'd0);
        chk("tickflag csn", 32'(oCsnRam), 32'hF);
        stepClk();
        chk("tickflag tickMiss clr", 32'(oTickMiss), 32'd0);

        // Valid write to bank 2, tap 5
        doWrite({2'd2, 4'd5}, 16'hA5A5);
        chk("wr b2t5 csn", 32'(oCsnRam), 32'hB);
        chk("wr b2t5 wrn", 32'(oWrnRam), 32'd0);
        chk("wr b2t5 addr", 32'(oAddrRam), 32'd5);
        chk("wr b2t5 data", 32'(oWtDtRam), 32'hA5A5);
        chk("wr b2t5 wrErr", 32'(oWrErr), 32'd0);
        stepClk();
        chk("wr idle csn", 32'(oCsnRam), 32'hF);
        chk("wr idle wrn", 32'(oWrnRam), 32'd1);

        // Highest legal tap
        doWrite({2'd0, 4'd9}, 16'h0909);
        chk("wr b0t9 csn", 32'(oCsnRam), 32'hE);
        chk("wr b0t9 addr", 32'(oAddrRam), 32'd9);
        chk("wr b0t9 wrErr", 32'(oWrErr), 32'd0);

        // Out-of-range taps
        doWrite({2'd1, 4'd12}, 16'h1212);
        chk("wr t12 wrErr", 32'(oWrErr), 32'd1);
        chk("wr t12 csn", 32'(oCsnRam), 32'hF);
        chk("wr t12 wrn", 32'(oWrnRam), 32'd1);
        doWrite({2'd3, 4'd10}, 16'h1010);
        chk("wr t10 wrErr", 32'(oWrErr), 32'd1);
        chk("wr t10 csn", 32'(oCsnRam), 32'hF);
        stepClk();
        chk("wr err clr", 32'(oWrErr), 32'd0);

        // Tick while in UPDATE
        iEnSample600k = 1'b1;
        stepClk();
        iEnSample600k = 1'b0;
        chk("upd tick tickMiss", 32'(oTickMiss), 32'd1);
        chk("upd tick enDelay", 32'(oEnDelay), 32'd0);
        chk("upd tick csn", 32'(oCsnRam), 32'hF);

        // Write in the last UPDATE cycle still issues
        iCoeffUpdateFlag = 1'b0;
        doWrite({2'd3, 4'd0}, 16'h1234);
        chk("lastwr csn", 32'(oCsnRam), 32'h7);
        chk("lastwr wrn", 32'(oWrnRam), 32'd0);
        chk("lastwr addr", 32'(oAddrRam), 32'd0);
        chk("lastwr data", 32'(oWtDtRam), 32'h1234);
        chk("lastwr wrReady", 32'(oWrReady), 32'd0);
        repeat (2) stepClk();

        // Second tick 6 cycles into a sweep is dropped
        runSweep("miss", 6, 0);
        stepClk();
        chk("miss post outValid", 32'(oOutValid), 32'd0);
        chk("miss post tickMiss", 32'(oTickMiss), 32'd0);
        repeat (4) stepClk();

        // Flag rises at sweep cycle 4: no write until after OUT
        runSweep("flag", 0, 3);
        chk("flag idle csn", 32'(oCsnRam), 32'hF);
        stepClk();
        chk("flag upd wrReady", 32'(oWrReady), 32'd1);
        chk("flag upd csn", 32'(oCsnRam), 32'hF);
        stepClk();
        iWrValid = 1'b0;
        chk("flag wr csn", 32'(oCsnRam), 32'hD);
        chk("flag wr wrn", 32'(oWrnRam), 32'd0);
        chk("flag wr addr", 32'(oAddrRam), 32'd3);
        chk("flag wr data", 32'(oWtDtRam), 32'hBEEF);
        iCoeffUpdateFlag = 1'b0;
        repeat (3) stepClk();

        // Reset at sweep cycle 5 abandons the sweep
        iEnSample600k = 1'b1;
        stepClk();
        iEnSample600k = 1'b0;
        repeat (3) stepClk();
        chk("midrst pre addr", 32'(oAddrRam), 32'd3);
        iRst = 1'b1;
        stepClk();
        iRst = 1'b0;
        chk("midrst csn", 32'(oCsnRam), 32'hF);
        chk("midrst wrn", 32'(oWrnRam), 32'd1);
        chk("midrst addr", 32'(oAddrRam), 32'd0);
        chk("midrst data", 32'(oWtDtRam), 32'd0);
        chk("midrst pulses", 32'({oEnDelay, oAccClr, oEnMul, oEnAddAcc, oOutValid, oTickMiss, oWrErr}), 32'd0);
        for (int k = 0; k < 14; k++) begin
            stepClk();
            chk($sformatf("midrst quiet outValid c%0d", k), 32'(oOutValid), 32'd0);
            chk($sformatf("midrst quiet csn c%0d", k), 32'(oCsnRam), 32'hF);
        end

        // Normal sweep after the abandoned one
        runSweep("postrst", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
